// File: rtl/uart_arb_pkg.sv
// Shared types and ASCII constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_TAG,
        ARB_SEP,
        ARB_DATA
    } arb_state_t;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;
    localparam logic [7:0] ASCII_COLON     = 8'h3A;

    // Hex digit for a requester id: 0-9 then A-F.
    function automatic logic [7:0] id_to_ascii(input logic [3:0] id);
        return (id < 4'd10) ? ASCII_ZERO + {4'b0000, id} : ASCII_ALPHA_OFS + {4'b0000, id};
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set bit of req starting at ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = IDX_W'((32'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between NUM_REQ
// byte streams, optionally prefixing each packet with "<id>:".
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter bit          TAG_EN  = 1'b1,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_tvalid,
    input  logic [NUM_REQ*8-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]   req_tlast,
    output logic [NUM_REQ-1:0]   req_tready,
    output logic                 tvalid,
    output logic [7:0]           tdata,
    input  logic                 tready,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             gv_q, gv_d;
    logic             tvalid_q, tvalid_d;
    logic [7:0]       tdata_q, tdata_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             load_ok;
    logic             sel_valid, sel_last;
    logic [7:0]       sel_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req_tvalid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Output register can take a byte when empty or draining this cycle.
    assign load_ok = !tvalid_q || tready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = req_tvalid[i];
                sel_last  = req_tlast[i];
                sel_data  = req_tdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        gv_d       = gv_q;
        tvalid_d   = tvalid_q && !tready;
        tdata_d    = tdata_q;
        req_tready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    gv_d    = 1'b1;
                    state_d = TAG_EN ? ARB_TAG : ARB_DATA;
                end
            end
            ARB_TAG: begin
                if (load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = id_to_ascii(4'(grant_q));
                    state_d  = ARB_SEP;
                end
            end
            ARB_SEP: begin
                if (load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = ASCII_COLON;
                    state_d  = ARB_DATA;
                end
            end
            ARB_DATA: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        req_tready[i] = load_ok;
                    end
                end
                if (sel_valid && load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = sel_data;
                    if (sel_last) begin
                        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                        gv_d    = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            gv_q     <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            gv_q     <= gv_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign tvalid      = tvalid_q;
    assign tdata       = tdata_q;
    assign grant_valid = gv_q;
    assign grant_idx   = grant_q;

endmodule
